regfile_mp: RTL and testbench

Parametrised multi-port register file with a write-back scoreboard; the next generation of the single-cycle core's 3-port register file. It provides NREAD combinational read ports, two synchronous write ports (ALU write-back and late load/multicycle write-back), an optional hardwired-zero register, and per-register busy tracking so the issue stage can stall on outstanding results. It sits between decode/issue and the write-back stage of the pipelined datapath.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/reg_scoreboard.sv | 64 ++++++
 rtl/regfile_mp.sv | 77 +++++++
 tb/tb_regfile_mp.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and packed-port helpers for the multi-port register file.
// Optional write-through forwarding is enabled by defining REGFILE_BYPASS_EN.
package regfile_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 32;
  localparam int DEF_NREAD = 2;

  // Low bit of lane i in a bus of w-bit lanes.
  function automatic int lane_lo(input int i, input int w);
    return i * w;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Busy bits for outstanding port-B results, with issue/clear arbitration and sb_err.
// REGFILE_BYPASS_EN hides busy for a register being cleared in the same cycle.
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH    = DEF_DEPTH,
  parameter int NREAD    = DEF_NREAD,
  parameter int ZERO_REG = 1,
  parameter int AW       = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               issue_en,
  input  logic [AW-1:0]      issue_addr,
  input  logic               clr_en,
  input  logic [AW-1:0]      clr_addr,
  input  logic [NREAD*AW-1:0] ra,
  output logic [NREAD-1:0]   busy_rd,
  output logic               sb_err
);

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;
  logic             set_ok;
  logic             clr_ok;
  logic             err_nxt;

  always_comb begin
    set_ok = issue_en && !(ZERO_REG != 0 && issue_addr == '0);
    clr_ok = clr_en && !(ZERO_REG != 0 && clr_addr == '0);
    busy_nxt = busy;
    if (clr_ok) busy_nxt[clr_addr] = 1'b0;
    // Set after clear: a new issue outranks the retiring result.
    if (set_ok) busy_nxt[issue_addr] = 1'b1;
    err_nxt = (set_ok && busy[issue_addr] &&
               !(clr_ok && clr_addr == issue_addr)) ||
              (clr_ok && !busy[clr_addr]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy   <= '0;
      sb_err <= 1'b0;
    end else begin
      busy   <= busy_nxt;
      sb_err <= err_nxt;
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_look
    logic [AW-1:0] a;
    logic          b;
    assign a = ra[lane_lo(i, AW) +: AW];
    always_comb begin
      b = busy[a];
`ifdef REGFILE_BYPASS_EN
      if (clr_en && clr_addr == a) b = 1'b0;
`endif
      if (ZERO_REG != 0 && a == '0) b = 1'b0;
    end
    assign busy_rd[i] = b;
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NREAD async reads, ALU and late write-back ports, scoreboard.
// REGFILE_BYPASS_EN forwards same-cycle write data to the read ports.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int NREAD    = DEF_NREAD,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   we_a,
  input  logic [AW-1:0]          wa_a,
  input  logic [WIDTH-1:0]       wd_a,
  input  logic                   we_b,
  input  logic [AW-1:0]          wa_b,
  input  logic [WIDTH-1:0]       wd_b,
  input  logic [NREAD*AW-1:0]    ra,
  output logic [NREAD*WIDTH-1:0] rd,
  output logic [NREAD-1:0]       busy_rd,
  input  logic                   issue_en,
  input  logic [AW-1:0]          issue_addr,
  output logic                   sb_err
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_a;
  logic             wr_b;

  assign wr_a = we_a && !(ZERO_REG != 0 && wa_a == '0);
  assign wr_b = we_b && !(ZERO_REG != 0 && wa_b == '0);

  // Port B is applied last so it wins a same-address collision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_a) mem[wa_a] <= wd_a;
      if (wr_b) mem[wa_b] <= wd_b;
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [AW-1:0]    a;
    logic [WIDTH-1:0] v;
    assign a = ra[lane_lo(i, AW) +: AW];
    always_comb begin
      v = mem[a];
`ifdef REGFILE_BYPASS_EN
      if (we_b && wa_b == a) v = wd_b;
      else if (we_a && wa_a == a) v = wd_a;
`endif
      if (ZERO_REG != 0 && a == '0) v = '0;
    end
    assign rd[lane_lo(i, WIDTH) +: WIDTH] = v;
  end

  reg_scoreboard #(
    .DEPTH    (DEPTH),
    .NREAD    (NREAD),
    .ZERO_REG (ZERO_REG),
    .AW       (AW)
  ) u_sb (
    .clk        (clk),
    .reset      (reset),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .clr_en     (we_b),
    .clr_addr   (wa_b),
    .ra         (ra),
    .busy_rd    (busy_rd),
    .sb_err     (sb_err)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp with four read ports and a hardwired zero register.
// Expectations follow REGFILE_BYPASS_EN when it is defined for the build.
module tb_regfile_mp;

  localparam int W  = 32;
  localparam int NR = 4;
  localparam int AW = 5;

  logic            clk = 1'b0;
  logic            reset;
  logic            we_a, we_b, issue_en;
  logic [AW-1:0]   wa_a, wa_b, issue_addr;
  logic [W-1:0]    wd_a, wd_b;
  logic [NR*AW-1:0] ra;
  logic [NR*W-1:0] rd;
  logic [NR-1:0]   busy_rd;
  logic            sb_err;

  int n_tests = 0;
  int n_fail  = 0;

  regfile_mp #(
    .WIDTH    (W),
    .DEPTH    (32),
    .NREAD    (NR),
    .ZERO_REG (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .we_a       (we_a),
    .wa_a       (wa_a),
    .wd_a       (wd_a),
    .we_b       (we_b),
    .wa_b       (wa_b),
    .wd_b       (wd_b),
    .ra         (ra),
    .rd         (rd),
    .busy_rd    (busy_rd),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .sb_err     (sb_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    we_a = 1'b0;
    we_b = 1'b0;
    issue_en = 1'b0;
    #1;
  endtask

  task automatic look(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                      input logic [AW-1:0] a2, input logic [AW-1:0] a3);
    ra = {a3, a2, a1, a0};
    #1;
  endtask

  task automatic wa(input logic [AW-1:0] a, input logic [W-1:0] d);
    we_a = 1'b1;
    wa_a = a;
    wd_a = d;
  endtask

  task automatic wb(input logic [AW-1:0] a, input logic [W-1:0] d);
    we_b = 1'b1;
    wa_b = a;
    wd_b = d;
  endtask

  task automatic iss(input logic [AW-1:0] a);
    issue_en = 1'b1;
    issue_addr = a;
  endtask

  initial begin
    reset = 1'b1;
    we_a = 0; we_b = 0; issue_en = 0;
    wa_a = '0; wa_b = '0; issue_addr = '0;
    wd_a = '0; wd_b = '0;
    ra = {5'd4, 5'd3, 5'd2, 5'd1};
    #12;
    chk("reset_rd", rd, '0);
    chk("reset_busy", busy_rd, '0);
    chk("reset_err", sb_err, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // write r5 and mark it busy, then reset with a write pending
    wa(5, 32'hDEADBEEF);
    iss(5);
    step();
    look(5, 0, 0, 0);
    chk("r5_written", rd[31:0], 32'hDEADBEEF);
    chk("r5_busy", busy_rd[0], 1'b1);
    wa(5, 32'h1234);
    iss(6);
    reset = 1'b1;
    #2;
    chk("midrst_rd", rd[31:0], '0);
    chk("midrst_busy", busy_rd[0], 1'b0);
    chk("midrst_err", sb_err, 1'b0);
    step();
    chk("midrst_pend", rd[31:0], '0);
    @(negedge clk);
    reset = 1'b0;

    // same-address collision: port B wins; B to non-busy flags error
    wa(3, 32'h11);
    wb(3, 32'h22);
    step();
    look(3, 0, 0, 0);
    chk("collide_b", rd[31:0], 32'h22);
    chk("wb_idle_err", sb_err, 1'b1);
    step();
    chk("err_pulse_end", sb_err, 1'b0);

    // register 0 ignores writes and raises no error
    wa(0, 32'hFFFF);
    wb(0, 32'h5555);
    step();
    look(0, 0, 0, 0);
    chk("r0_zero", rd[31:0], '0);
    chk("r0_no_err", sb_err, 1'b0);

    // four-port packed read
    wa(1, 1);
    step();
    wa(2, 2);
    step();
    wa(3, 3);
    step();
    look(1, 2, 3, 0);
    chk("four_port", rd, {32'd0, 32'd3, 32'd2, 32'd1});

    // issue r7 then retire it through port B
    iss(7);
    look(7, 0, 0, 0);
    chk("r7_not_yet", busy_rd[0], 1'b0);
    step();
    chk("r7_busy", busy_rd[0], 1'b1);
    wb(7, 32'h55);
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("r7_byp_busy", busy_rd[0], 1'b0);
    chk("r7_byp_rd", rd[31:0], 32'h55);
`else
    chk("r7_wb_busy", busy_rd[0], 1'b1);
    chk("r7_wb_rd", rd[31:0], 32'h0);
`endif
    step();
    chk("r7_clear", busy_rd[0], 1'b0);
    chk("r7_rd", rd[31:0], 32'h55);
    chk("r7_no_err", sb_err, 1'b0);

    // double issue
    iss(7);
    step();
    chk("iss1_err", sb_err, 1'b0);
    iss(7);
    step();
    chk("iss2_err", sb_err, 1'b1);
    step();
    chk("iss2_end", sb_err, 1'b0);
    wb(7, 32'h77);
    step();
    chk("r7_ret_err", sb_err, 1'b0);

    // write-back to idle r9
    wb(9, 32'h99);
    step();
    chk("r9_err", sb_err, 1'b1);

    // set wins over clear on r4
    iss(4);
    step();
    chk("r4_iss_err", sb_err, 1'b0);
    iss(4);
    wb(4, 32'hAB);
    step();
    look(4, 0, 0, 0);
    chk("r4_busy", busy_rd[0], 1'b1);
    chk("r4_no_err", sb_err, 1'b0);
    chk("r4_rd", rd[31:0], 32'hAB);

    // issue to r0 is ignored
    iss(0);
    step();
    look(4, 0, 0, 0);
    chk("r0_iss_busy", busy_rd[3:1], 3'b000);
    chk("r0_iss_err", sb_err, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
